atm_pager_readback: RTL and testbench

//  Responder for Z80 IN from port xxBE. Returns the paging state written via the xxF7 ports.

---
 rtl/atm_pager_readback.sv | 101 ++++++++++
 tb/tb_atm_pager_readback.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_pager_readback.sv
// atm_pager_readback: IN xxBE responder returning the xxF7 paging state.
// Snapshots the selected register at IN start and holds it until the cycle ends.
module atm_pager_readback #(
    parameter logic [7:0] UNMAPPED_VAL = 8'hFF
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic [7:0]  za_hi,
    input  logic        portbe_stb,
    input  logic        iord_n,
    input  logic [31:0] rd_page0_w,
    input  logic [31:0] rd_page1_w,
    input  logic [7:0]  rd_ramnrom,
    input  logic [7:0]  rd_dos7ffd,
    output logic [7:0]  zd_out,
    output logic        zd_oe,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        HOLD    = 2'd2,
        WAITEND = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  idx;
    logic        load_en;
    logic [7:0]  decoded;
    logic [31:0] page_bus;
    logic [4:0]  page_sh;

    // Select the register addressed by the latched index
    always_comb begin
        page_bus = idx[0] ? rd_page1_w : rd_page0_w;
        page_sh  = {idx[2:1], 3'b000};
        decoded  = UNMAPPED_VAL;
        if (idx[7:3] == 5'd0) begin
            decoded = page_bus[page_sh +: 8];
        end else if (idx == 8'h08) begin
            decoded = rd_ramnrom;
        end else if (idx == 8'h09) begin
            decoded = rd_dos7ffd;
        end
    end

    // Next-state logic; a new strobe always restarts the read
    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (portbe_stb) state_nxt = LOAD;
            end
            LOAD: begin
                if (portbe_stb) begin
                    state_nxt = LOAD;
                end else begin
                    load_en   = 1'b1;
                    state_nxt = iord_n ? WAITEND : HOLD;
                end
            end
            HOLD: begin
                if (portbe_stb)  state_nxt = LOAD;
                else if (iord_n) state_nxt = IDLE;
            end
            WAITEND: begin
                state_nxt = portbe_stb ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latch the index at every strobe, including restarts
    always_ff @(posedge fclk or posedge rst) begin
        if (rst)             idx <= 8'h00;
        else if (portbe_stb) idx <= za_hi;
    end

    // Snapshot data and registered bus controls
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            zd_out <= 8'h00;
            zd_oe  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            if (load_en) zd_out <= decoded;
            zd_oe <= (state_nxt == HOLD);
            busy  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_atm_pager_readback.sv
// tb_atm_pager_readback: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference.
module tb_atm_pager_readback;

    logic        fclk = 1'b0;
    logic        rst;
    logic [7:0]  za_hi;
    logic        portbe_stb;
    logic        iord_n;
    logic [31:0] rd_page0_w;
    logic [31:0] rd_page1_w;
    logic [7:0]  rd_ramnrom;
    logic [7:0]  rd_dos7ffd;
    logic [7:0]  zd_out;
    logic        zd_oe;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    atm_pager_readback #(.UNMAPPED_VAL(8'hFF)) dut (
        .fclk       (fclk),
        .rst        (rst),
        .za_hi      (za_hi),
        .portbe_stb (portbe_stb),
        .iord_n     (iord_n),
        .rd_page0_w (rd_page0_w),
        .rd_page1_w (rd_page1_w),
        .rd_ramnrom (rd_ramnrom),
        .rd_dos7ffd (rd_dos7ffd),
        .zd_out     (zd_out),
        .zd_oe      (zd_oe),
        .busy       (busy)
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: value the Z80 should see for a given index right now
    function automatic logic [7:0] ref_val(input logic [7:0] i);
        logic [31:0] v;
        if (i < 8) begin
            v = (i % 2 == 1) ? rd_page1_w : rd_page0_w;
            v = v >> (8 * (i / 2));
            return v[7:0];
        end
        if (i == 8) return rd_ramnrom;
        if (i == 9) return rd_dos7ffd;
        return 8'hFF;
    endfunction

    // Transaction model: age = edges since the strobe (-1 = no read)
    int         m_age = -1;
    logic [7:0] m_idx = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic       m_oe = 1'b0;
    logic       m_busy = 1'b0;

    always @(posedge fclk or posedge rst) begin
        if (rst) begin
            m_age  = -1;
            m_data = 8'h00;
            m_oe   = 1'b0;
            m_busy = 1'b0;
        end else if (portbe_stb) begin
            m_idx  = za_hi;
            m_age  = 0;
            m_oe   = 1'b0;
            m_busy = 1'b1;
        end else if (m_age == 0) begin
            m_data = ref_val(m_idx);
            m_oe   = !iord_n;
            m_busy = 1'b1;
            m_age  = 1;
        end else if (!(m_age == 1 && m_oe && !iord_n)) begin
            m_oe   = 1'b0;
            m_busy = 1'b0;
            m_age  = -1;
        end
    end

    logic cmp_en = 1'b0;

    // Per-cycle comparison against the model
    always @(negedge fclk) begin
        if (cmp_en) begin
            chk("zd_out", zd_out, m_data);
            chk("zd_oe", {7'd0, zd_oe}, {7'd0, m_oe});
            chk("busy", {7'd0, busy}, {7'd0, m_busy});
        end
    end

    task automatic tick();
        @(negedge fclk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] i);
        za_hi      = i;
        portbe_stb = 1'b1;
        tick();
        portbe_stb = 1'b0;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        za_hi      = 8'h00;
        portbe_stb = 1'b0;
        iord_n     = 1'b1;
        rd_page0_w = 32'h0;
        rd_page1_w = 32'h0;
        rd_ramnrom = 8'h0;
        rd_dos7ffd = 8'h0;
        #3;
        chk("rst_out", zd_out, 8'h00);
        chk("rst_oe", {7'd0, zd_oe}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        tick();
        tick();
        rst    = 1'b0;
        cmp_en = 1'b1;

        // 1: page read with a normal IN cycle
        rd_page1_w = 32'h0000_A500;
        iord_n = 1'b0;
        pulse(8'h03);
        chk("t1_data", zd_out, 8'hA5);
        chk("t1_oe", {7'd0, zd_oe}, 8'h01);
        repeat (6) tick();
        chk("t1_oe_hold", {7'd0, zd_oe}, 8'h01);
        iord_n = 1'b1;
        tick();
        chk("t1_oe_off", {7'd0, zd_oe}, 8'h00);
        chk("t1_idle", {7'd0, busy}, 8'h00);

        // 2: ramnrom and dos7ffd registers
        rd_ramnrom = 8'b10_01_11_00;
        iord_n = 1'b0;
        pulse(8'h08);
        chk("t2_ramnrom", zd_out, 8'h9C);
        iord_n = 1'b1;
        tick();
        rd_dos7ffd = 8'h3F;
        iord_n = 1'b0;
        pulse(8'h09);
        chk("t2_dos", zd_out, 8'h3F);
        iord_n = 1'b1;
        tick();

        // 3: unmapped indices
        iord_n = 1'b0;
        pulse(8'h0A);
        chk("t3_0a", zd_out, 8'hFF);
        chk("t3_0a_oe", {7'd0, zd_oe}, 8'h01);
        iord_n = 1'b1;
        tick();
        iord_n = 1'b0;
        pulse(8'h40);
        chk("t3_40", zd_out, 8'hFF);
        iord_n = 1'b1;
        tick();

        // 4: later writes do not disturb the snapshot
        rd_page0_w[7:0] = 8'h11;
        iord_n = 1'b0;
        pulse(8'h00);
        rd_page0_w[7:0] = 8'h22;
        repeat (4) tick();
        chk("t4_snap", zd_out, 8'h11);
        chk("t4_oe", {7'd0, zd_oe}, 8'h01);
        iord_n = 1'b1;
        tick();

        // 5: reset in the middle of HOLD
        iord_n = 1'b0;
        pulse(8'h01);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_out", zd_out, 8'h00);
        chk("t5_oe", {7'd0, zd_oe}, 8'h00);
        chk("t5_busy", {7'd0, busy}, 8'h00);
        tick();
        rst = 1'b0;
        pulse(8'h03);
        chk("t5_again", zd_out, 8'hA5);
        iord_n = 1'b1;
        tick();

        // 6: aborted cycle, then restart during HOLD
        za_hi      = 8'h05;
        portbe_stb = 1'b1;
        tick();
        portbe_stb = 1'b0;
        tick();
        chk("t6_wait_oe", {7'd0, zd_oe}, 8'h00);
        chk("t6_wait_busy", {7'd0, busy}, 8'h01);
        tick();
        chk("t6_idle", {7'd0, busy}, 8'h00);
        iord_n = 1'b0;
        pulse(8'h03);
        chk("t6_first", zd_out, 8'hA5);
        rd_page1_w[31:24] = 8'h77;
        za_hi      = 8'h07;
        portbe_stb = 1'b1;
        tick();
        chk("t6_gap", {7'd0, zd_oe}, 8'h00);
        portbe_stb = 1'b0;
        tick();
        chk("t6_new", zd_out, 8'h77);
        chk("t6_new_oe", {7'd0, zd_oe}, 8'h01);
        iord_n = 1'b1;
        tick();

        // Randomized traffic against the model
        repeat (3000) begin
            rst        = ($urandom_range(0, 299) == 0);
            portbe_stb = ($urandom_range(0, 5) == 0);
            za_hi      = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                     : 8'($urandom_range(0, 11));
            iord_n     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) rd_page0_w = $urandom;
            if ($urandom_range(0, 3) == 0) rd_page1_w = $urandom;
            if ($urandom_range(0, 3) == 0) rd_ramnrom = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rd_dos7ffd = 8'($urandom);
            tick();
        end

        rst        = 1'b0;
        portbe_stb = 1'b0;
        iord_n     = 1'b1;
        repeat (3) tick();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
